// File: rtl/flash_xip_cache.sv
// Direct-mapped, word-granular read cache between the CPU APB port and the SPI/XIP controller.
// Flash-window reads are served from the cache or refilled downstream; other addresses pass straight through.
module flash_xip_cache #(
    parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
    parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
    parameter int unsigned IDX_W      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr,
    input  logic        flush,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    // state       | meaning
    // IDLE        | waiting for an upstream access phase, classify it
    // RESP        | one-cycle upstream in_pready with registered rdata/err
    // MISS_SETUP  | downstream read setup for a cache refill
    // MISS_ACCESS | downstream read access, wait for out_pready, then fill
    // PASS_SETUP  | downstream setup for a non-flash access
    // PASS_ACCESS | downstream access for a non-flash access
    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned TAG_W   = 24 - (IDX_W + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESP,
        S_MISS_SETUP,
        S_MISS_ACCESS,
        S_PASS_SETUP,
        S_PASS_ACCESS
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [2:0]         pprot_q, pprot_d;
    logic               pwrite_q, pwrite_d;
    logic [31:0]        pwdata_q, pwdata_d;
    logic [3:0]         pstrb_q, pstrb_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               suppress_q, suppress_d;
    logic [31:0]        hit_cnt_q, hit_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;
    logic [ENTRIES-1:0] valid_q, valid_d;

    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    logic [31:0]        data_mem [ENTRIES];

    logic [IDX_W-1:0]   lkp_idx, fill_idx;
    logic [TAG_W-1:0]   lkp_tag, fill_tag;
    logic               in_flash, lkp_hit, fill_en;

    assign lkp_idx  = in_paddr[IDX_W+1:2];
    assign lkp_tag  = in_paddr[23:IDX_W+2];
    assign fill_idx = addr_q[IDX_W+1:2];
    assign fill_tag = addr_q[23:IDX_W+2];
    assign in_flash = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
    assign lkp_hit  = valid_q[lkp_idx] && (tag_mem[lkp_idx] == lkp_tag);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pprot_d    = pprot_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        suppress_d = suppress_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = valid_q;
        fill_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_psel && in_penable) begin
                    if (in_flash && !in_pwrite) begin
                        if (lkp_hit) begin
                            rdata_d   = data_mem[lkp_idx];
                            err_d     = 1'b0;
                            hit_cnt_d = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 32'd1;
                            state_d   = S_RESP;
                        end else begin
                            addr_d     = {in_paddr[31:2], 2'b00};
                            pprot_d    = in_pprot;
                            pwrite_d   = 1'b0;
                            pwdata_d   = '0;
                            pstrb_d    = '0;
                            suppress_d = 1'b0;
                            miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 32'd1;
                            state_d    = S_MISS_SETUP;
                        end
                    end else if (in_flash) begin
                        // flash is read-only through this path
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        addr_d   = in_paddr;
                        pprot_d  = in_pprot;
                        pwrite_d = in_pwrite;
                        pwdata_d = in_pwdata;
                        pstrb_d  = in_pstrb;
                        state_d  = S_PASS_SETUP;
                    end
                end
            end
            S_RESP:       state_d = S_IDLE;
            S_MISS_SETUP: state_d = S_MISS_ACCESS;
            S_MISS_ACCESS: begin
                if (out_pready) begin
                    rdata_d = out_prdata;
                    err_d   = out_pslverr;
                    fill_en = !out_pslverr && !suppress_q && !flush;
                    state_d = S_RESP;
                end
            end
            S_PASS_SETUP: state_d = S_PASS_ACCESS;
            S_PASS_ACCESS: begin
                if (out_pready) begin
                    rdata_d = out_prdata;
                    err_d   = out_pslverr;
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
        end
        // a flush anywhere in the refill window poisons that refill
        if (flush) begin
            valid_d = '0;
            if (state_q == S_MISS_SETUP || state_q == S_MISS_ACCESS) begin
                suppress_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            pprot_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            suppress_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pprot_q    <= pprot_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            suppress_q <= suppress_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
        end
    end

    // line storage needs no reset; valid_q gates every use
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= out_prdata;
        end
    end

    always_comb begin
        out_psel    = (state_q == S_MISS_SETUP) || (state_q == S_MISS_ACCESS) ||
                      (state_q == S_PASS_SETUP) || (state_q == S_PASS_ACCESS);
        out_penable = (state_q == S_MISS_ACCESS) || (state_q == S_PASS_ACCESS);
        out_paddr   = out_psel ? addr_q   : '0;
        out_pprot   = out_psel ? pprot_q  : '0;
        out_pwrite  = out_psel ? pwrite_q : 1'b0;
        out_pwdata  = out_psel ? pwdata_q : '0;
        out_pstrb   = out_psel ? pstrb_q  : '0;
        in_pready   = (state_q == S_RESP);
        in_prdata   = in_pready ? rdata_q : '0;
        in_pslverr  = in_pready ? err_q   : 1'b0;
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_flash_xip_cache.sv
// Directed bench for flash_xip_cache: upstream APB driver, downstream XIP slave model, protocol monitor.
module tb_flash_xip_cache;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_paddr = '0;
    logic        in_psel = 1'b0, in_penable = 1'b0, in_pwrite = 1'b0;
    logic [2:0]  in_pprot = '0;
    logic [31:0] in_pwdata = '0;
    logic [3:0]  in_pstrb = '0;
    logic        in_pready, in_pslverr;
    logic [31:0] in_prdata;
    logic [31:0] out_paddr, out_pwdata, out_prdata;
    logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
    logic [2:0]  out_pprot;
    logic [3:0]  out_pstrb;
    logic        flush = 1'b0;
    logic [31:0] hit_cnt, miss_cnt;

    int          n_chk = 0, n_bad = 0;
    logic        ds_stall = 1'b0, ds_err = 1'b0;
    int          salt = 0;
    int          ds_cnt = 0, proto_err = 0, stab_err = 0;
    logic [31:0] su_addr, su_wdata, last_addr, last_wdata;
    logic        su_write, last_write;
    logic [3:0]  su_strb, last_strb;
    logic [2:0]  su_prot, last_prot;
    logic [31:0] rd;
    logic        err;
    int          acc;

    always #5 clock = ~clock;

    flash_xip_cache dut (
        .clock(clock), .reset(reset),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable), .in_pprot(in_pprot),
        .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
        .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
        .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot),
        .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
        .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr),
        .flush(flush), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    function automatic logic [31:0] dsf(input logic [31:0] a, input int s);
        return {a[15:0], a[31:16]} ^ ((s != 0) ? 32'h0F0F_5A5A : 32'h1357_9BDF);
    endfunction

    assign out_pready  = ~ds_stall;
    assign out_pslverr = ds_err;
    assign out_prdata  = dsf(out_paddr, salt);

    always begin
        @(negedge clock);
        #1;
        if (out_penable && !out_psel) proto_err++;
        if (out_psel && !out_penable) begin
            su_addr = out_paddr; su_write = out_pwrite; su_wdata = out_pwdata;
            su_strb = out_pstrb; su_prot = out_pprot;
        end
        if (out_psel && out_penable) begin
            if (out_paddr !== su_addr || out_pwrite !== su_write || out_pwdata !== su_wdata ||
                out_pstrb !== su_strb || out_pprot !== su_prot) stab_err++;
            if (out_pready) begin
                ds_cnt++;
                last_addr = out_paddr; last_write = out_pwrite; last_wdata = out_pwdata;
                last_strb = out_pstrb; last_prot = out_pprot;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [2:0] prot, input logic fl,
                       output logic [31:0] rdo, output logic erro, output int acco);
        @(negedge clock);
        in_paddr = addr; in_pwrite = wr; in_pwdata = wd; in_pstrb = wr ? 4'hF : 4'h0;
        in_pprot = prot; in_psel = 1'b1; in_penable = 1'b0;
        @(negedge clock);
        in_penable = 1'b1;
        if (fl) flush = 1'b1;
        acco = 1;
        while (!in_pready && acco < 40) begin
            @(negedge clock);
            flush = 1'b0;
            acco++;
        end
        flush = 1'b0;
        rdo = in_prdata;
        erro = in_pslverr;
        if (!in_pready) chk("pready_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        in_psel = 1'b0; in_penable = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_d,
                           input int exp_acc, input logic fl);
        apb(addr, 1'b0, 32'd0, 3'b101, fl, rd, err, acc);
        chk({tag, "_data"}, rd, exp_d);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        if (exp_acc > 0) chk({tag, "_acc"}, acc, exp_acc);
    endtask

    task automatic chk_cnt(input string tag, input int h, input int m, input int d);
        chk({tag, "_hit"}, hit_cnt, h);
        chk({tag, "_miss"}, miss_cnt, m);
        chk({tag, "_ds"}, ds_cnt, d);
    endtask

    task automatic wait_penable(input string tag);
        for (int i = 0; i < 40 && !out_penable; i++) @(negedge clock);
        if (!out_penable) chk({tag, "_wait"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_pready", {31'd0, in_pready}, 32'd0);
        chk("rst_psel", {31'd0, out_psel}, 32'd0);
        chk("rst_paddr", out_paddr, 32'd0);
        chk("rst_prdata", in_prdata, 32'd0);
        chk("rst_cnt", hit_cnt | miss_cnt, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // cold miss then hits; slave data changes so hits must come from the cache
        do_read("cold", 32'h3000_0040, dsf(32'h3000_0040, 0), 4, 1'b0);
        chk_cnt("cold", 0, 1, 1);
        chk("cold_addr", last_addr, 32'h3000_0040);
        chk("cold_prot", {29'd0, last_prot}, 32'd5);
        chk("cold_strb", {28'd0, last_strb}, 32'd0);
        salt = 1;
        do_read("hit", 32'h3000_0040, dsf(32'h3000_0040, 0), 2, 1'b0);
        chk_cnt("hit", 1, 1, 1);
        do_read("hit_lo", 32'h3000_0043, dsf(32'h3000_0040, 0), 2, 1'b0);
        chk_cnt("hit_lo", 2, 1, 1);

        // eviction by a second tag on index 0
        do_read("evict", 32'h3000_0440, dsf(32'h3000_0440, 1), 4, 1'b0);
        chk("evict_addr", last_addr, 32'h3000_0440);
        do_read("refetch", 32'h3000_0040, dsf(32'h3000_0040, 1), 4, 1'b0);
        chk_cnt("refetch", 2, 3, 3);
        do_read("rehit", 32'h3000_0040, dsf(32'h3000_0040, 1), 2, 1'b0);

        apb(32'h3000_0000, 1'b1, 32'hDEAD_BEEF, 3'b000, 1'b0, rd, err, acc);
        chk("fwr_err", {31'd0, err}, 32'd1);
        chk("fwr_data", rd, 32'd0);
        chk("fwr_acc", acc, 2);
        chk_cnt("fwr", 3, 3, 3);

        // pass-through write and read of SPI registers
        apb(32'h1000_1018, 1'b1, 32'd1, 3'b010, 1'b0, rd, err, acc);
        chk("pw_acc", acc, 4);
        chk("pw_addr", last_addr, 32'h1000_1018);
        chk("pw_write", {31'd0, last_write}, 32'd1);
        chk("pw_wdata", last_wdata, 32'd1);
        chk("pw_strb", {28'd0, last_strb}, 32'hF);
        chk("pw_prot", {29'd0, last_prot}, 32'd2);
        do_read("pr", 32'h1000_1010, dsf(32'h1000_1010, 1), 4, 1'b0);
        chk("pr_addr", last_addr, 32'h1000_1010);
        chk("pr_write", {31'd0, last_write}, 32'd0);
        chk_cnt("pass", 3, 3, 5);

        // downstream errors: forwarded, and an errored refill is not kept
        ds_err = 1'b1;
        apb(32'h2000_0000, 1'b0, 32'd0, 3'b000, 1'b0, rd, err, acc);
        chk("perr_err", {31'd0, err}, 32'd1);
        apb(32'h3000_0100, 1'b0, 32'd0, 3'b000, 1'b0, rd, err, acc);
        chk("merr_err", {31'd0, err}, 32'd1);
        ds_err = 1'b0;
        do_read("merr_re", 32'h3000_0100, dsf(32'h3000_0100, 1), 4, 1'b0);
        do_read("merr_hit", 32'h3000_0100, dsf(32'h3000_0100, 1), 2, 1'b0);
        chk_cnt("merr", 4, 5, 8);

        // flush during a stalled refill: data returned, fill discarded
        ds_stall = 1'b1;
        fork
            do_read("fl_miss", 32'h3000_0084, dsf(32'h3000_0084, 1), 0, 1'b0);
            begin
                wait_penable("fl");
                flush = 1'b1;
                @(negedge clock);
                flush = 1'b0;
                repeat (2) @(negedge clock);
                ds_stall = 1'b0;
            end
        join
        do_read("fl_again", 32'h3000_0084, dsf(32'h3000_0084, 1), 4, 1'b0);
        do_read("fl_hit", 32'h3000_0084, dsf(32'h3000_0084, 1), 2, 1'b0);
        chk_cnt("fl", 5, 7, 10);

        // flush in the same cycle as the fill
        ds_stall = 1'b1;
        fork
            do_read("ff_miss", 32'h3000_00C8, dsf(32'h3000_00C8, 1), 0, 1'b0);
            begin
                wait_penable("ff");
                repeat (2) @(negedge clock);
                flush = 1'b1;
                ds_stall = 1'b0;
                @(negedge clock);
                flush = 1'b0;
            end
        join
        do_read("ff_again", 32'h3000_00C8, dsf(32'h3000_00C8, 1), 4, 1'b0);
        do_read("ff_hit", 32'h3000_00C8, dsf(32'h3000_00C8, 1), 2, 1'b0);
        chk_cnt("ff", 6, 9, 12);

        // flush coincident with a lookup hits on the old valid bits
        do_read("fi_hit", 32'h3000_00C8, dsf(32'h3000_00C8, 1), 2, 1'b1);
        do_read("fi_miss", 32'h3000_00C8, dsf(32'h3000_00C8, 1), 4, 1'b0);
        chk_cnt("fi", 7, 10, 13);

        chk("proto_err", proto_err, 0);
        chk("stab_err", stab_err, 0);

        // reset in the middle of a stalled refill
        ds_stall = 1'b1;
        @(negedge clock);
        in_paddr = 32'h3000_0084; in_pwrite = 1'b0; in_pstrb = 4'h0; in_psel = 1'b1; in_penable = 1'b0;
        @(negedge clock);
        in_penable = 1'b1;
        wait_penable("rst_mid");
        #2;
        reset = 1'b1;
        #1;
        chk("rmid_psel", {31'd0, out_psel}, 32'd0);
        chk("rmid_pen", {31'd0, out_penable}, 32'd0);
        chk("rmid_cnt", miss_cnt, 32'd0);
        @(negedge clock);
        in_psel = 1'b0; in_penable = 1'b0; ds_stall = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        do_read("rmid_re", 32'h3000_0084, dsf(32'h3000_0084, 1), 4, 1'b0);
        chk("rmid_miss", miss_cnt, 32'd1);
        chk("rmid_hitc", hit_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
